// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   - Widths of the WB/M/EX control bundles carried through ID/EX.
//   - Bit positions inside the M bundle.
//   - State type for the hazard/stall sequencer.
package mips_pipe_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline statistics.
//   clk   in   pipeline clock
//   rst   in   asynchronous active-high reset, clears count
//   inc   in   add one this cycle (ignored once all-ones)
//   count out  current value, sticks at 2^CNT_W-1
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS core.
// Detects load-use hazards, freezes the pipeline while data memory is busy,
// flushes IF/ID and ID/EX on a taken branch resolved in MEM, and keeps
// saturating stall/flush statistics plus a sticky memory-timeout flag.
//
// Ports:
//   clk, rst                 pipeline clock / async active-high reset
//   id_rs, id_rt, id_uses_rt source registers of the instruction in ID
//   ex_mem_read, ex_rt       load in EX and its destination register
//   mem_valid, mem_ready     data-memory handshake of the MEM stage
//   branch_taken             taken branch resolved in MEM
//   pc_write, if_id_write, id_ex_write   register load enables
//   id_ex_bubble, if_id_flush            squash controls
//   mem_timeout              sticky: memory wait reached WAIT_MAX
//   stall_cnt, flush_cnt     saturating statistics
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | no memory access outstanding from the previous cycle
// MEM_WAIT | memory was busy last cycle; wait_cnt counts busy cycles
module hazard_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_valid,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WC_W       = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WAIT_MAX_C = WC_W'(WAIT_MAX);

  logic lu_hazard;
  logic mem_busy;

  // $zero is never a real dependency, so a load to r0 never stalls.
  assign lu_hazard = ex_mem_read & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mem_busy  = mem_valid & ~mem_ready;

  hz_state_t       state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next state
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          if (wait_cnt_q != WAIT_MAX_C) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    // Flag rises together with wait_cnt reaching WAIT_MAX, i.e. right
    // after the WAIT_MAX-th consecutive busy cycle.
    if (mem_busy && (wait_cnt_d == WAIT_MAX_C)) begin
      mem_timeout_d = 1'b1;
    end
  end

  // Outputs: priority mem_busy > branch_taken > lu_hazard > normal.
  // A branch or hazard seen during a freeze is simply re-evaluated on the
  // release cycle since its inputs are held by the frozen pipeline.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
    end else if (branch_taken) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (lu_hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

  logic stall_inc;
  logic flush_inc;

  // During reset the counters are held clear, so ~pc_write needs no gate.
  assign stall_inc = ~pc_write;
  assign flush_inc = branch_taken & ~mem_busy & ~rst;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
